// File: rtl/sequence_game_controller.sv
// Memory-game sequencer: plays back ROM steps 0..round as LED patterns, then checks
// one-hot button presses against the same ROM entries, advancing up to 16 rounds.
module sequence_game_controller #(
    parameter int unsigned SHOW_CYCLES    = 1000,
    parameter int unsigned GAP_CYCLES     = 250,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] buttons,
    output logic [3:0] rom_address,
    input  logic [3:0] rom_data,
    output logic [3:0] leds,
    output logic [3:0] round,
    output logic       playing,
    output logic       won,
    output logic       lost
);

    localparam int unsigned MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH_SHOW, SHOW, GAP, WAIT_RELEASE, WAIT_PRESS,
        FETCH_CHECK, COMPARE, NEXT_ROUND, WIN, LOSE
    } state_t;

    state_t        state, next_state;
    logic [3:0]    step;
    logic [3:0]    press_reg;
    logic [TW-1:0] timer;
    logic          last_step;

    assign rom_address = step;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (start) next_state = FETCH_SHOW;
            FETCH_SHOW:   next_state = SHOW;
            SHOW:         if (timer == SHOW_LAST) next_state = GAP;
            GAP:          if (timer == GAP_LAST) next_state = last_step ? WAIT_RELEASE : FETCH_SHOW;
            WAIT_RELEASE: if (buttons == '0) next_state = WAIT_PRESS;
            WAIT_PRESS: begin
                if (buttons != '0)              next_state = FETCH_CHECK;
                else if (timer == TIMEOUT_LAST) next_state = LOSE;
            end
            FETCH_CHECK:  next_state = COMPARE;
            COMPARE: begin
                if (press_reg != rom_data) next_state = LOSE;
                else if (step == round)    next_state = NEXT_ROUND;
                else                       next_state = WAIT_RELEASE;
            end
            NEXT_ROUND:   if (buttons == '0) next_state = (round == 4'd15) ? WIN : FETCH_SHOW;
            WIN, LOSE:    if (start) next_state = FETCH_SHOW;
            default:      next_state = IDLE;
        endcase
    end

    always_comb begin
        playing = 1'b0;
        won     = 1'b0;
        lost    = 1'b0;
        case (state)
            IDLE:    ;
            WIN:     won = 1'b1;
            LOSE:    lost = 1'b1;
            default: playing = 1'b1;
        endcase
    end

    // step advances when leaving SHOW (not GAP) so the ROM has already produced the
    // next entry by the time FETCH_SHOW samples it; last_step keeps the GAP decision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step      <= '0;
            round     <= '0;
            leds      <= '0;
            timer     <= '0;
            press_reg <= '0;
            last_step <= 1'b0;
        end else begin
            if (next_state != state)
                timer <= '0;
            else if (state == SHOW || state == GAP || state == WAIT_PRESS)
                timer <= timer + 1'b1;

            case (state)
                IDLE, WIN, LOSE: if (start) begin
                    round <= '0;
                    step  <= '0;
                    leds  <= '0;
                end
                FETCH_SHOW: leds <= rom_data;
                SHOW: if (timer == SHOW_LAST) begin
                    leds      <= '0;
                    last_step <= (step == round);
                    step      <= (step == round) ? '0 : step + 1'b1;
                end
                WAIT_RELEASE: if (buttons == '0) leds <= '0;
                WAIT_PRESS:   if (buttons != '0) press_reg <= buttons;
                COMPARE: if (press_reg == rom_data) begin
                    leds <= press_reg;
                    step <= (step == round) ? '0 : step + 1'b1;
                end
                NEXT_ROUND: if (buttons == '0) begin
                    if (round == 4'd15) begin
                        leds <= '1;
                    end else begin
                        leds  <= '0;
                        round <= round + 1'b1;
                    end
                end
                default: ;
            endcase

            if (next_state == LOSE && state != LOSE) begin
                step <= '0;
                leds <= '0;
            end
        end
    end

endmodule
